// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer around one shared full_adder cell.
// Ports: clk, rst (sync, active-high), start/a/b/cin request, busy (SHIFT), done (one-cycle pulse),
//        sum/cout registered result, ovf signed overflow (only with SERIAL_ADD_OVF_EN defined).
// Optional feature macro: SERIAL_ADD_OVF_EN.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last;
    full_adder u_fa (.x(a_sh[0]), .y(b_sh[0]), .ci(carry), .s(fa_s), .co(fa_co));
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {fa_s, res[WIDTH-1:1]};
                        cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry reg still holds the carry into the MSB on this step
                        ovf   <= carry ^ fa_co;
`endif
                    end
                end
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4, ovf4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    int         checks = 0, errors = 0;
    logic [9:0] q8[$];
    logic [4:0] q4[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(4)) d4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf4)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v = (a[7] == b[7]) && (t[7] != a[7]);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back({v, t});
        tick(1);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = $urandom;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL accept busy=%b done=%b required busy=1 done=0", busy8, done8);
        end
    endtask

    task automatic wait_done(input int lat);
        int         n;
        logic [9:0] e;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        e = q8.pop_front();
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL done_timeout waited=%0d cycles required done", n);
        end else begin
            if (n != lat) begin
                errors++;
                $display("FAIL latency got=%0d required=%0d", n, lat);
            end
            checks++;
            if ({cout8, sum8} !== e[8:0] || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL result cout,sum=%h busy=%b required %h busy=0", {cout8, sum8}, busy8, e[8:0]);
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ovf8 !== e[9]) begin
                errors++;
                $display("FAIL ovf got=%b required=%b", ovf8, e[9]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", {busy8, done8, sum8, cout8, ovf8});
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_quiet saw busy/done=1 required 0 for 20 cycles");
        end
    endtask

    task automatic test_basic();
        logic [16:0] v[3] = '{{8'h00, 8'h00, 1'b0}, {8'hA5, 8'h5A, 1'b1}, {8'h0F, 8'h01, 1'b0}};
        foreach (v[i]) begin
            issue(v[i][16:9], v[i][8:1], v[i][0]);
            wait_done(8);
            tick(1);
            checks++;
            if (done8 !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got=%b required=0", done8);
            end
        end
    endtask

    task automatic test_ovf();
        issue(8'h7F, 8'h01, 1'b0);
        wait_done(8);
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(8);
        issue(8'h80, 8'h80, 1'b0);
        wait_done(8);
    endtask

    task automatic test_ignore();
        logic bad;
        tick(2);
        issue(8'h12, 8'h34, 1'b0);
        tick(2);
        a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
        wait_done(5);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL start_ignored saw extra operation required none");
        end
    endtask

    task automatic test_back_to_back();
        issue(8'h21, 8'h43, 1'b1);
        wait_done(8);
        issue(8'hC8, 8'h64, 1'b0);
        wait_done(8);
    endtask

    task automatic test_reset_mid();
        logic bad;
        issue(8'hFF, 8'hFF, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        void'(q8.pop_back());
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h required=0", {busy8, done8, sum8, cout8});
        end
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (done8 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_done saw done=1 required 0");
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] i9;
        logic [4:0] e;
        for (int i = 0; i < 512; i++) begin
            i9 = 9'(i);
            a4 = i9[3:0]; b4 = i9[7:4]; cin4 = i9[8]; start4 = 1'b1;
            q4.push_back({1'b0, i9[3:0]} + {1'b0, i9[7:4]} + {4'd0, i9[8]});
            tick(1);
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL w4_accept i=%0d busy=%b done=%b required busy=1 done=0", i, busy4, done4);
            end
            tick(4);
            e = q4.pop_front();
            checks++;
            if (done4 !== 1'b1 || {cout4, sum4} !== e) begin
                errors++;
                $display("FAIL w4_result i=%0d done=%b cout,sum=%h required done=1 %h", i, done4, {cout4, sum4}, e);
            end
        end
        start4 = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer built around a single instance of the team's one-bit `full_adder` cell. It accepts two WIDTH-bit operands and a carry-in under a start/done handshake. It then feeds them LSB-first through the full adder, one bit per clock, with a registered carry. It returns the WIDTH-bit sum and carry-out, trading WIDTH cycles of latency for one adder cell of area. The block is the control layer that owns and schedules the shared full-adder datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only when state is IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high while state is SHIFT.
- `done`  out  1  one-cycle pulse; high while state is DONE.
- `sum`  out  WIDTH  result; registered.
- `cout`  out  1  carry-out; registered.
- `ovf`  out  1  signed overflow; registered. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- State machine has three states: IDLE, SHIFT and DONE.
- IDLE with `start`=1: on the next edge, load shift regs `a_sh`←`a` and `b_sh`←`b`. Load carry reg ←`cin` and bit counter ←0. Move to SHIFT.
- IDLE with `start`=0: stay in IDLE.
- SHIFT, each edge:
  - The `full_adder` is driven by `a_sh[0]`, `b_sh[0]` and the carry reg.
  - Its sum bit enters the MSB of the internal result shift reg; that reg shifts right.
  - `a_sh` and `b_sh` shift right, zero-filled.
  - Carry reg ←adder cout; counter +1.
- SHIFT end: on the edge where counter = WIDTH-1, go to DONE. On that same edge, load `sum` ←completed result and `cout` ←final carry.
- DONE:
  - `done`=1 for exactly one cycle.
  - `start`=1: accept new operands, same as from IDLE, and go to SHIFT. Back-to-back operation is allowed.
  - `start`=0: go to IDLE.
- `start` in SHIFT is ignored; the request is dropped, not queued.
- `sum`, `cout` and `ovf` change only on the edge that enters DONE. They hold their values otherwise, including across later starts, until the next completion.
- Counter width is clog2(WIDTH). Counter, shift regs and result reg are internal and are not exported.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, unsigned, modulo 2^(WIDTH+1).

## Timing
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Internal regs are cleared.
- Reset has priority over `start` and over every state transition.
- Reset mid-SHIFT aborts the operation: no `done` pulse and the result is discarded.
- Latency, with `start` accepted at edge E0:
  - `busy` is high for the WIDTH cycles after edges E0..E(WIDTH-1).
  - The result registers update at edge E(WIDTH).
  - `done` is high in the cycle after E(WIDTH).
- Throughput: one operation per WIDTH+1 cycles when `start` is held high.
- Operands only need to be valid in the accepting cycle.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- Defined:
  - The `ovf` port exists.
  - On the MSB step, the carry into the MSB (carry reg before the step) is captured.
  - `ovf` ←(carry into MSB) XOR (carry out of MSB), loaded together with `sum`.
  - Reset value is 0.
- Undefined: the `ovf` port and its capture logic are absent. All other behaviour is identical.

## Test plan
WIDTH=8 unless noted.
- Reset and idle: hold rst 3 cycles, then release with start=0 → all outputs 0, `busy`=0, and no `done` for 20 cycles.
- Basic adds:
  - a=0x00, b=0x00, cin=0 → `done` in cycle 9 after acceptance, `sum`=0x00, `cout`=0.
  - a=0xA5, b=0x5A, cin=1 → `sum`=0x00, `cout`=1.
  - a=0x0F, b=0x01, cin=0 → `sum`=0x10, `cout`=0.
- Overflow (macro defined):
  - a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `ovf`=1.
  - a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0.
- Handshake:
  - Pulse start with a=0x03 and b=0x04 during SHIFT cycle 3 → ignored; the original result completes unchanged.
  - Start held high in the DONE cycle with new operands → `busy` in the next cycle, and a second `done` 9 cycles later with the correct second sum.
- Reset mid-op: assert rst in SHIFT cycle 4 of a=0xFF, b=0xFF → the next cycle shows state IDLE, `sum`=0, `cout`=0, and no `done` pulse.
- Exhaustive (WIDTH=4): all 512 combinations of a, b and cin, run back-to-back → {`cout`,`sum`} equals a+b+cin each time, and `done` arrives every 5 cycles.
